shift_ctrl: RTL and testbench

SHIFT_CTRL -- requirements
Module: shift_ctrl

---
 rtl/shift_ctrl_pkg.sv | 17 +
 rtl/piso_reg.sv | 40 ++++
 rtl/shift_ctrl.sv | 116 +++++++++++
 tb/tb_shift_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared types and constants for the shift_ctrl serializer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package shift_ctrl_pkg;

  // Controller states; encodings are fixed so other blocks and debug
  // tooling can decode a captured state value directly.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Width of the inter-word idle counter; covers gap lengths up to 15.
  localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/piso_reg.sv
// Parallel-in / serial-out register: loads a word, shifts one bit per step.
// Latency: q_bit shows the first serial bit the cycle after load.
// Backpressure: none; load and shift are commands from the controller.
//
// Ports:
//   clk    rising-edge clock
//   rst    asynchronous active-low reset, clears the register
//   load   capture d (has priority over shift)
//   shift  advance the register by one bit toward the output end
//   d      parallel word
//   q_bit  current serial bit (MSB end or LSB end per MSB_FIRST)
module piso_reg #(
  parameter int BITS      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            shift,
  input  logic [BITS-1:0] d,
  output logic            q_bit
);

  logic [BITS-1:0] sreg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sreg <= '0;
    end else if (load) begin
      sreg <= d;
    end else if (shift) begin
      // Shift away from the output end so the next bit lands there.
      if (MSB_FIRST) sreg <= {sreg[BITS-2:0], 1'b0};
      else           sreg <= {1'b0, sreg[BITS-1:1]};
    end
  end

  assign q_bit = MSB_FIRST ? sreg[BITS-1] : sreg[0];

endmodule

// File: rtl/shift_ctrl.sv
// Word serializer: accepts a parallel word, sends it one bit per cycle, then idles GAP cycles.
// Latency: first serial bit the cycle after accept; done on the last of BITS bits.
// Backpressure: din_ready only in IDLE with abort low; words offered while busy are ignored.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   din, din_valid    parallel word offer; din_ready signals acceptance this cycle
//   abort             drop the word in flight (and block accepts) on the next edge
//   sout, sout_valid  serial bit and its qualifier (only in SHIFT)
//   busy              controller not in IDLE
//   done              one-cycle pulse on the last bit of a completed word
module shift_ctrl #(
  parameter int BITS      = 8,
  parameter int GAP       = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] din,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic            abort,
  output logic            sout,
  output logic            sout_valid,
  output logic            busy,
  output logic            done
);

  import shift_ctrl_pkg::*;

  // The GAP parameter shadows the package's GAP state literal, so the
  // state is always named with its package prefix in this module.
  localparam int                   CW       = $clog2(BITS);
  localparam logic [CW-1:0]        CNT_LAST = CW'(BITS - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_t                 state;
  state_t                 state_nxt;
  logic [CW-1:0]          bit_cnt;
  logic [GAP_CNT_W-1:0]   gap_cnt;
  logic                   accept;
  logic                   shift_step;
  logic                   q_bit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    din_ready  = 1'b0;
    accept     = 1'b0;
    shift_step = 1'b0;
    sout_valid = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        // abort blocks acceptance so a simultaneous offer is never taken.
        din_ready = !abort;
        accept    = din_valid && !abort;
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        sout_valid = 1'b1;
        done       = (bit_cnt == '0) && !abort;
        if (abort) begin
          state_nxt = IDLE;
        end else begin
          shift_step = 1'b1;
          if (bit_cnt == '0) state_nxt = (GAP > 0) ? shift_ctrl_pkg::GAP : IDLE;
        end
      end
      shift_ctrl_pkg::GAP: begin
        if (abort || gap_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bit_cnt counts remaining bits down to 0 (the last bit); gap_cnt is
  // loaded with GAP-1 on the last bit so GAP lasts exactly GAP cycles.
  // Both hold at 0 rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      if (accept)
        bit_cnt <= CNT_LAST;
      else if (shift_step && bit_cnt != '0)
        bit_cnt <= bit_cnt - 1'b1;

      if (shift_step && bit_cnt == '0)
        gap_cnt <= GAP_LOAD;
      else if (state == shift_ctrl_pkg::GAP && !abort && gap_cnt != '0)
        gap_cnt <= gap_cnt - 1'b1;
    end
  end

  piso_reg #(
    .BITS      (BITS),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (shift_step),
    .d     (din),
    .q_bit (q_bit)
  );

  assign sout = q_bit && (state == SHIFT);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: three configurations share one stimulus stream.
// Instance 0: GAP=2 MSB first, instance 1: GAP=2 LSB first, instance 2: GAP=0 MSB first.
// A word-level model predicts every output each cycle; directed phases pin literal timings.
module tb_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_valid = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] din_ready, sout, sout_valid, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_ctrl #(.BITS(8), .GAP(2), .MSB_FIRST(1'b1)) dut_a (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[0]),
    .abort(abort), .sout(sout[0]), .sout_valid(sout_valid[0]), .busy(busy[0]), .done(done[0]));

  shift_ctrl #(.BITS(8), .GAP(2), .MSB_FIRST(1'b0)) dut_b (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[1]),
    .abort(abort), .sout(sout[1]), .sout_valid(sout_valid[1]), .busy(busy[1]), .done(done[1]));

  shift_ctrl #(.BITS(8), .GAP(0), .MSB_FIRST(1'b1)) dut_c (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready[2]),
    .abort(abort), .sout(sout[2]), .sout_valid(sout_valid[2]), .busy(busy[2]), .done(done[2]));

  function automatic int gap_of(input int i);
    return (i == 2) ? 0 : 2;
  endfunction

  function automatic bit msb_of(input int i);
    return (i != 1);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-level model: bits still to send, idle cycles still owed, and the word.
  int         rem_m [3];
  int         gap_m [3];
  logic [7:0] word_m [3];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        rem_m[i]  = 0;
        gap_m[i]  = 0;
        word_m[i] = 8'h00;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (abort) begin
          rem_m[i] = 0;
          gap_m[i] = 0;
        end else if (rem_m[i] > 0) begin
          rem_m[i]--;
          if (rem_m[i] == 0) gap_m[i] = gap_of(i);
        end else if (gap_m[i] > 0) begin
          gap_m[i]--;
        end else if (din_valid) begin
          word_m[i] = din;
          rem_m[i]  = 8;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the rising edge.
  int k_c;
  bit ev_c, eb_c, ed_c, ebusy_c, erdy_c;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      ev_c    = (rem_m[i] > 0);
      k_c     = ev_c ? 8 - rem_m[i] : 0;
      eb_c    = ev_c ? (msb_of(i) ? word_m[i][7 - k_c] : word_m[i][k_c]) : 1'b0;
      ed_c    = (rem_m[i] == 1) && !abort;
      ebusy_c = (rem_m[i] > 0) || (gap_m[i] > 0);
      erdy_c  = !ebusy_c && !abort;
      chk($sformatf("model_sout_valid%0d", i), int'(sout_valid[i]), int'(ev_c));
      chk($sformatf("model_sout%0d", i),       int'(sout[i]),       int'(eb_c));
      chk($sformatf("model_done%0d", i),       int'(done[i]),       int'(ed_c));
      chk($sformatf("model_busy%0d", i),       int'(busy[i]),       int'(ebusy_c));
      chk($sformatf("model_din_ready%0d", i),  int'(din_ready[i]),  int'(erdy_c));
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    din_valid = 1'b0;
    abort     = 1'b0;
    while (busy != 3'b000 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_wait", int'(busy), 0);
  endtask

  task automatic accept_word(input logic [7:0] w);
    din       = w;
    din_valid = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  // Called at the start of cycle 1 after an accept edge (cycle 0).
  task automatic after_accept(input string tag, input logic [7:0] seq_a, input logic [7:0] seq_b);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k <= 8) begin
        chk({tag, "_sout_a"}, int'(sout[0]), int'(seq_a[8 - k]));
        chk({tag, "_sout_b"}, int'(sout[1]), int'(seq_b[8 - k]));
      end
      chk({tag, "_done_a"}, int'(done[0]),      int'(k == 8));
      chk({tag, "_rdy_a"},  int'(din_ready[0]), int'(k == 11));
      chk({tag, "_rdy_c"},  int'(din_ready[2]), int'(k >= 9));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",       int'(busy),       0);
    chk("rst_sout_valid", int'(sout_valid), 0);
    chk("rst_done",       int'(done),       0);
    chk("rst_din_ready",  int'(din_ready),  7);

    // Release with a word already offered: the first edge must accept it.
    din       = 8'hA5;
    din_valid = 1'b1;
    rst       = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    after_accept("a5", 8'hA5, 8'hA5);

    wait_idle();
    accept_word(8'h01);
    after_accept("w01", 8'h01, 8'h80);

    // din_valid held high across two words.
    wait_idle();
    din       = 8'hFF;
    din_valid = 1'b1;
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      chk("held_done_a", int'(done[0]),      int'(k == 8 || k == 19));
      chk("held_rdy_a",  int'(din_ready[0]), int'(k == 0 || k == 11));
      if (k <= 11) begin
        chk("held_rdy_c",  int'(din_ready[2]), int'(k == 0 || k == 9));
        chk("held_done_c", int'(done[2]),      int'(k == 8));
      end
      @(posedge clk); #1;
      if (k == 0)  din = 8'h00;
      if (k == 11) din_valid = 1'b0;
    end

    // Abort during cycle 4 of a word.
    wait_idle();
    accept_word(8'hA5);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      chk("abort_done_a", int'(done[0]), 0);
      if (k == 4) chk("abort_valid_c4", int'(sout_valid[0]), 1);
      if (k == 5) begin
        chk("abort_busy_c5",  int'(busy[0]),       0);
        chk("abort_valid_c5", int'(sout_valid[0]), 0);
        chk("abort_rdy_c5",   int'(din_ready[0]),  1);
      end
      @(posedge clk); #1;
      abort = (k == 3);
    end

    // abort wins over an offer in IDLE.
    wait_idle();
    din       = 8'h55;
    din_valid = 1'b1;
    abort     = 1'b1;
    @(negedge clk);
    chk("abort_idle_rdy", int'(din_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    din_valid = 1'b0;
    abort     = 1'b0;

    // Reset mid-word, then a clean word after release.
    wait_idle();
    accept_word(8'hA5);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_sout",       int'(sout),       0);
    chk("rstmid_sout_valid", int'(sout_valid), 0);
    chk("rstmid_done",       int'(done),       0);
    chk("rstmid_busy",       int'(busy),       0);
    chk("rstmid_rdy",        int'(din_ready),  7);
    @(posedge clk);
    @(negedge clk);
    chk("rstmid_hold_busy", int'(busy), 0);
    din       = 8'h3C;
    din_valid = 1'b1;
    rst       = 1'b1;
    @(posedge clk); #1;
    din_valid = 1'b0;
    after_accept("w3c", 8'h3C, 8'h3C);

    // Randomized traffic with occasional abort and reset pulses.
    wait_idle();
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      din       = 8'($urandom);
      din_valid = 1'($urandom_range(0, 1));
      abort     = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    wait_idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
